// File: rtl/fifo_word_packer_if.sv
// Bundle of the FIFO-read side and the packed-word stream side of the word packer.
interface fifo_word_packer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BYTES  = 4
);
  logic [DATA_W-1:0]       rdata;
  logic                    rempty;
  logic                    read_enable;
  logic                    flush;
  logic [DATA_W*BYTES-1:0] out_data;
  logic [BYTES-1:0]        out_keep;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;

  // Packer side
  modport master (
    input  rdata, rempty, flush, out_ready,
    output read_enable, out_data, out_keep, out_last, out_valid, busy
  );

  // FIFO / downstream side
  modport slave (
    output rdata, rempty, flush, out_ready,
    input  read_enable, out_data, out_keep, out_last, out_valid, busy
  );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops bytes from the async FIFO read port and packs them little-endian into
// BYTES-wide words on a valid/ready stream; a flush closes a partial word.
module fifo_word_packer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BYTES  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_word_packer_if.master   bus
);

  localparam int unsigned CNT_W  = $clog2(BYTES + 1);
  localparam int unsigned WORD_W = DATA_W * BYTES;

  logic [BYTES-1:0][DATA_W-1:0] asm_q, asm_d, asm_w;
  logic [CNT_W-1:0]             cnt_q, cnt_d, cnt_w;
  logic                         inflight_q;
  logic                         flush_pend_q, flush_pend_d;
  logic [WORD_W-1:0]            out_data_q, out_data_d;
  logic [BYTES-1:0]             out_keep_q, out_keep_d;
  logic                         out_last_q, out_last_d;
  logic                         out_valid_q, out_valid_d;
  logic [BYTES-1:0]             part_keep_c;
  logic                         read_enable_c;
  logic                         pop_c;
  logic                         slot_free_c;

  // Pop only while there is room for every byte already requested
  assign read_enable_c = rst & ~flush_pend_q &
                         ((32'(cnt_q) + 32'(inflight_q)) < 32'(BYTES));
  assign pop_c         = read_enable_c & ~bus.rempty;
  assign slot_free_c   = ~out_valid_q | bus.out_ready;

  assign bus.read_enable = read_enable_c;
  assign bus.out_data    = out_data_q;
  assign bus.out_keep    = out_keep_q;
  assign bus.out_last    = out_last_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = (cnt_q != '0) | inflight_q | out_valid_q | flush_pend_q;

  // Assembly, flush handling and output-slot loading
  always_comb begin
    asm_w = asm_q;
    cnt_w = cnt_q;
    if (inflight_q) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (CNT_W'(i) == cnt_q) asm_w[i] = bus.rdata;
      end
      cnt_w = cnt_q + CNT_W'(1);
    end

    for (int unsigned i = 0; i < BYTES; i++) begin
      part_keep_c[i] = (CNT_W'(i) < cnt_q);
    end

    asm_d        = asm_w;
    cnt_d        = cnt_w;
    flush_pend_d = flush_pend_q | bus.flush;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q & ~bus.out_ready;

    if (flush_pend_q && !inflight_q) begin
      // Last byte has landed: close whatever is assembled
      if (cnt_q == '0) begin
        flush_pend_d = 1'b0;
      end else if (slot_free_c) begin
        out_data_d   = asm_q;
        out_keep_d   = part_keep_c;
        out_last_d   = 1'b1;
        out_valid_d  = 1'b1;
        cnt_d        = '0;
        asm_d        = '0;
        flush_pend_d = 1'b0;
      end
    end else if ((cnt_w == CNT_W'(BYTES)) && slot_free_c) begin
      // Full word, bypassing the landing byte straight into the slot
      out_data_d  = asm_w;
      out_keep_d  = '1;
      out_last_d  = flush_pend_q;
      out_valid_d = 1'b1;
      cnt_d       = '0;
      asm_d       = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q        <= '0;
      cnt_q        <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      cnt_q        <= cnt_d;
      inflight_q   <= pop_c;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: FIFO model, scoreboard of expected words.
module tb_fifo_word_packer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_word_packer_if #(.DATA_W(8), .BYTES(4)) bif ();

  fifo_word_packer #(.DATA_W(8), .BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  fifo_q[$];
  logic [36:0] exp_q[$];

  logic        pend      = 1'b0;
  logic [7:0]  pend_byte = 8'h00;
  int          ready_mode = 0;   // 0: always ready, 1: never, 2: random
  bit          rand_gaps  = 1'b0;
  bit          model_on   = 1'b0;
  logic [31:0] acc_word   = 32'h0;
  int          acc_n      = 0;
  int          cyc        = 0;
  int          pop_cnt    = 0;
  int          words_out  = 0;
  int          first_pop_cyc   = -1;
  int          first_valid_cyc = -1;
  bit          stall_prev = 1'b0;
  logic [36:0] held_word  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of FIFO model, downstream model and output checking
  task automatic tick(input logic fl);
    logic [36:0] cur;
    @(negedge clk);
    cyc++;
    cur = {bif.out_data, bif.out_keep, bif.out_last};
    if (stall_prev) begin
      check("hold_valid", 64'(bif.out_valid), 64'(1));
      check("hold_word", 64'(cur), 64'(held_word));
    end
    if (bif.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

    bif.rdata  = pend ? pend_byte : 8'($urandom);
    pend       = 1'b0;
    bif.rempty = (fifo_q.size() == 0) || (rand_gaps && ($urandom_range(0, 3) == 0));
    case (ready_mode)
      0:       bif.out_ready = 1'b1;
      1:       bif.out_ready = 1'b0;
      default: bif.out_ready = 1'($urandom_range(0, 1));
    endcase
    bif.flush = fl;

    if (bif.read_enable && !bif.rempty) begin
      pend      = 1'b1;
      pend_byte = fifo_q.pop_front();
      pop_cnt++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      if (model_on) begin
        acc_word[acc_n*8 +: 8] = pend_byte;
        acc_n++;
        if (acc_n == 4) begin
          exp_q.push_back({acc_word, 4'hF, 1'b0});
          acc_n = 0;
        end
      end
    end

    if (bif.out_valid && bif.out_ready) begin
      words_out++;
      check("sb_word_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) check("sb_word", 64'(cur), 64'(exp_q.pop_front()));
    end
    stall_prev = bif.out_valid && !bif.out_ready;
    held_word  = cur;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || pend || bif.busy) && n < max_cycles) begin
      tick(1'b0);
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_idle"}, 64'(bif.busy), 64'(0));
  endtask

  initial begin
    int p0, w0;
    rst           = 1'b0;
    bif.rempty    = 1'b0;
    bif.rdata     = 8'h00;
    bif.flush     = 1'b0;
    bif.out_ready = 1'b0;

    // Reset with FIFO claiming data: nothing may pop
    repeat (3) @(negedge clk);
    check("rst_read_enable", 64'(bif.read_enable), 64'(0));
    check("rst_outputs", 64'({bif.out_data, bif.out_keep, bif.out_last, bif.out_valid}), 64'(0));
    check("rst_busy", 64'(bif.busy), 64'(0));
    bif.rempty = 1'b1;
    rst        = 1'b1;
    @(negedge clk);
    check("release_read_enable", 64'(bif.read_enable), 64'(1));

    // Basic pack and first-word latency
    ready_mode = 0;
    first_pop_cyc   = -1;
    first_valid_cyc = -1;
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.push_back({32'h44332211, 4'hF, 1'b0});
    drain("pack", 50);
    check("pack_latency", 64'(first_valid_cyc - first_pop_cyc), 64'(5));

    // Backpressure: two words with the slot blocked
    ready_mode = 1;
    p0 = pop_cnt;
    w0 = words_out;
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    exp_q.push_back({32'h44332211, 4'hF, 1'b0});
    exp_q.push_back({32'h88776655, 4'hF, 1'b0});
    repeat (20) tick(1'b0);
    check("bp_valid", 64'(bif.out_valid), 64'(1));
    check("bp_word1", 64'(bif.out_data), 64'(32'h44332211));
    check("bp_read_enable", 64'(bif.read_enable), 64'(0));
    check("bp_pops", 64'(pop_cnt - p0), 64'(8));
    ready_mode = 0;
    drain("bp", 50);
    check("bp_words", 64'(words_out - w0), 64'(2));

    // Flush of a two-byte partial word, then normal packing resumes
    fifo_q = '{8'hAA, 8'hBB};
    repeat (5) tick(1'b0);
    check("fl_no_early_word", 64'(bif.out_valid), 64'(0));
    exp_q.push_back({32'h0000BBAA, 4'h3, 1'b1});
    tick(1'b1);
    drain("flush", 50);
    fifo_q = '{8'h05, 8'h06, 8'h07, 8'h08};
    exp_q.push_back({32'h08070605, 4'hF, 1'b0});
    drain("resume", 50);

    // Flush coinciding with the third pop
    p0 = pop_cnt;
    fifo_q = '{8'h01, 8'h02, 8'h03};
    exp_q.push_back({32'h00030201, 4'h7, 1'b1});
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    check("race_pops", 64'(pop_cnt - p0), 64'(3));
    drain("race", 50);

    // Flush with nothing assembled yields no word
    w0 = words_out;
    tick(1'b1);
    repeat (6) tick(1'b0);
    check("empty_flush_words", 64'(words_out - w0), 64'(0));
    check("empty_flush_idle", 64'(bif.busy), 64'(0));

    // Random stream with backpressure and FIFO gaps
    ready_mode = 2;
    rand_gaps  = 1'b1;
    model_on   = 1'b1;
    acc_n      = 0;
    w0 = words_out;
    for (int i = 0; i < 400; i++) fifo_q.push_back(8'($urandom));
    drain("stream", 20000);
    check("stream_words", 64'(words_out - w0), 64'(100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
